grid_mem_arbiter: RTL and testbench
===================================

# grid_mem_arbiter

Grid memory arbiter: shares the single-port 256-byte grid memory between the line clearer, the piece placer and the display renderer. Each requester holds a request for as long as it needs exclusive ownership of the memory. A multi-cycle read-modify-write burst, such as a line shift, is therefore never split. The block sits between the requesters and the grid memory macro, and muxes address, write enable and write data onto the memory.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters; index 0 = line clearer, 1 = piece placer, 2 = renderer.
- MAX_HOLD, 64: ownership cycle limit; used only when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester ownership request; level, held for the whole burst.
- req_we  in  NUM_REQ  per-requester write enable.
- req_addr  in  NUM_REQ*8  packed addresses; requester i is bits [8i+7:8i].
- req_wdata  in  NUM_REQ*8  packed write data.
- gnt  out  NUM_REQ  one-hot (or zero) ownership grant, registered.
- rvalid  out  NUM_REQ  per-requester read-data-valid strobe, registered.
- rdata  out  8  read data, broadcast to all requesters; equals mem_rdata.
- mem_addr  out  8  grid memory address.
- mem_we  out  1  grid memory write enable.
- mem_wdata  out  8  grid memory write data.
- mem_rdata  in  8  grid memory read data; synchronous read, 1-cycle latency.

## Operation
- Two states:
  - IDLE: gnt == 0.
  - OWNED: exactly one gnt bit set; owner index held in a register.
- IDLE: on each edge, if any req bit is high, grant the first set bit in rotating priority order, starting at last_owner+1 mod NUM_REQ.
  - last_owner resets to NUM_REQ-1, so requester 0 wins first after reset.
- OWNED, owner req still high: grant kept.
- OWNED, owner req low at an edge (release):
  - If another req is pending, gnt moves directly to the next requester in rotating order on that edge. There is no idle cycle.
  - If no other req is pending, go to IDLE.
  - last_owner <= owner in both cases.
- Memory mux is combinational from the gnt register:
  - mem_addr, mem_we and mem_wdata come from the granted requester.
  - With no grant, all three are 0.
  - req_we from a non-granted requester never reaches mem_we.
- rvalid[i] is set for one cycle following each cycle in which gnt[i] = 1 and req_we[i] = 0; otherwise it is 0.
- A requester must not issue accesses while its gnt is 0.
- Asserting req does not imply an access. An access happens on every cycle with gnt high.
- Async reset, including mid-burst: gnt = 0, rvalid = 0, and mem_* = 0 immediately; state = IDLE; hold counter = 0; last_owner = NUM_REQ-1.

## Timing
- Grant latency: req rising in IDLE at cycle t → gnt at t+1. Earliest memory access is at t+1; read data and rvalid are at t+2.
- Handover latency: owner drops req at cycle t → new gnt at t+1.
  - A read issued by the old owner on its last granted cycle still returns rvalid to the old owner at t+1.
- Simultaneous release of the owner and a new request on the same edge: the new request is arbitrated normally on that edge.
- Back-to-back reads by the owner give one rvalid per cycle, continuously.

## Configuration
- GRID_ARB_TIMEOUT_EN, defined:
  - The hold counter increments each OWNED cycle and resets on every grant change.
  - When the counter reaches MAX_HOLD-1 and any other req is pending, the grant is revoked on the next edge and passed on in rotating order. The revoked owner gets the lowest priority.
  - If nothing else is pending, the counter saturates and the grant is kept.
  - A revoked requester waits with req held until it is granted again.
- GRID_ARB_TIMEOUT_EN, undefined: there is no counter; ownership lasts until req drops. MAX_HOLD is ignored.

## Structure
- Shared package grid_pkg holds:
  - GRID_ADDR_W = 8 and GRID_DATA_W = 8.
  - Grid geometry constants: LINE_1 = 1, LINE_OFFSET = 12, LINE_WIDTH = 10, NUM_LINES = 20.
  - Requester index constants: REQ_CLEAR = 0, REQ_PLACE = 1, REQ_RENDER = 2.
- One sub-module, rr_pick: combinational rotating-priority encoder with inputs req and last_owner, producing a one-hot pick and a pick-valid output.

## Test plan
- Single read: mem[13] = 0x05; req[0] high with addr 13 at t → gnt = 001 at t+1, mem_addr = 13; rvalid = 001 and rdata = 0x05 at t+2.
- Contention: all req bits rise together after reset, each owner holds for 4 cycles then releases → gnt sequence 001, 010, 100, each lasting 4 cycles, with no idle cycle between grants.
- Write masking: requester 1 drives we = 1, addr 40, data 0xFF while gnt = 001 → mem_we = 0 and mem[40] unchanged.
- Timeout, GRID_ARB_TIMEOUT_EN defined, MAX_HOLD = 64: requester 1 holds req for 200 cycles while req[0] is pending → gnt moves to 001 after exactly 64 cycles of gnt = 010.
  - Same stimulus with the macro undefined → gnt = 010 for all 200 cycles.
- Reset mid-burst: rst driven low during an OWNED write → gnt, mem_we and rvalid go to 0 with no clock edge. After release, req[2] alone is granted within 1 cycle.

Source files
------------

// File: rtl/grid_mem_arbiter_pkg.sv
// Shared grid definitions: memory geometry, requester indices and arbiter state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Package grid_pkg
//   GRID_ADDR_W / GRID_DATA_W : grid memory address and data widths
//   LINE_*                    : playfield geometry inside the 256-byte grid
//   REQ_*                     : fixed requester slot assignment on the arbiter
package grid_pkg;

   localparam int GRID_ADDR_W = 8;
   localparam int GRID_DATA_W = 8;

   // Playfield geometry: line n starts at LINE_1 + (n-1)*LINE_OFFSET.
   localparam int LINE_1      = 1;
   localparam int LINE_OFFSET = 12;
   localparam int LINE_WIDTH  = 10;
   localparam int NUM_LINES   = 20;

   localparam int REQ_CLEAR   = 0;
   localparam int REQ_PLACE   = 1;
   localparam int REQ_RENDER  = 2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/grid_mem_arbiter_if.sv
// Requester-side and memory-side bus of the grid memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: ownership handshake via req/gnt; no per-access stall.
//
// Signals: req/req_we/req_addr/req_wdata (requesters -> arbiter),
//          gnt/rvalid/rdata (arbiter -> requesters),
//          mem_addr/mem_we/mem_wdata (arbiter -> memory), mem_rdata (memory -> arbiter).
// Modports: slave = arbiter view, master = requesters + memory view.
interface grid_mem_arbiter_if #(
   parameter int NUM_REQ = 3
);
   import grid_pkg::*;

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ*GRID_ADDR_W-1:0] req_addr;
   logic [NUM_REQ*GRID_DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]             gnt;
   logic [NUM_REQ-1:0]             rvalid;
   logic [GRID_DATA_W-1:0]         rdata;
   logic [GRID_ADDR_W-1:0]         mem_addr;
   logic                           mem_we;
   logic [GRID_DATA_W-1:0]         mem_wdata;
   logic [GRID_DATA_W-1:0]         mem_rdata;

   modport slave (
      input  req, req_we, req_addr, req_wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output req, req_we, req_addr, req_wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/grid_mem_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req bit after last_owner, wrapping.
// Latency: combinational.
// Backpressure: none.
//
// Ports: req (candidate bits), last_owner (index searched after),
//        pick (one-hot winner), pick_vld (any candidate present).
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic [NUM_REQ-1:0] pick,
   output logic               pick_vld
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      // last_owner itself is visited last (k == NUM_REQ), giving it lowest priority.
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
         if (!pick_vld && req[idx]) begin
            pick[idx] = 1'b1;
            pick_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/grid_mem_arbiter.sv
// Shares the single-port grid memory between clearer, placer and renderer by exclusive ownership.
// Latency: gnt 1 cycle after req; handover 1 cycle after release; rvalid 1 cycle after a granted read.
// Backpressure: a requester holds req until gnt; ownership is kept while req stays high.
//
// Ports: clk, rst (async, active-low), bus (grid_mem_arbiter_if.slave).
// Optional feature macro GRID_ARB_TIMEOUT_EN: revoke ownership after MAX_HOLD cycles when
// another requester is waiting; otherwise MAX_HOLD is unused and ownership lasts until release.
module grid_mem_arbiter
   import grid_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int MAX_HOLD = 64
) (
   input  logic               clk,
   input  logic               rst,
   grid_mem_arbiter_if.slave  bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (MAX_HOLD < 2) begin : g_max_hold_chk
      $error("grid_mem_arbiter: MAX_HOLD must be at least 2");
   end

   arb_state_t         state;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   last_owner;
   logic [NUM_REQ-1:0] gnt_q;
   logic [NUM_REQ-1:0] rvalid_q;

   logic [NUM_REQ-1:0] cand;
   logic [IDX_W-1:0]   base;
   logic [NUM_REQ-1:0] pick;
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic               hold_expired;
   logic               owner_leaves;

   // The current owner is never a candidate, so a revoked owner ends up behind everyone else.
   assign cand = bus.req & ~gnt_q;
   assign base = (state == ARB_OWNED) ? owner : last_owner;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req        (cand),
      .last_owner (base),
      .pick       (pick),
      .pick_vld   (pick_vld)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = IDX_W'(i);
      end
   end

`ifdef GRID_ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD);
   logic [HOLD_W-1:0] hold_cnt;
   assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
   assign hold_expired = 1'b0;
`endif

   // Release, or timeout with someone waiting (a lone owner past the limit keeps the grant).
   assign owner_leaves = !bus.req[owner] || (hold_expired && pick_vld);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ARB_IDLE;
         owner      <= '0;
         last_owner <= IDX_W'(NUM_REQ - 1);
         gnt_q      <= '0;
         rvalid_q   <= '0;
`ifdef GRID_ARB_TIMEOUT_EN
         hold_cnt   <= '0;
`endif
      end else begin
         // Every granted cycle is an access; reads return one cycle later.
         rvalid_q <= gnt_q & ~bus.req_we;

         case (state)
            ARB_IDLE: begin
               if (pick_vld) begin
                  state <= ARB_OWNED;
                  owner <= pick_idx;
                  gnt_q <= pick;
`ifdef GRID_ARB_TIMEOUT_EN
                  hold_cnt <= '0;
`endif
               end
            end
            ARB_OWNED: begin
               if (owner_leaves) begin
                  last_owner <= owner;
`ifdef GRID_ARB_TIMEOUT_EN
                  hold_cnt   <= '0;
`endif
                  if (pick_vld) begin
                     owner <= pick_idx;
                     gnt_q <= pick;
                  end else begin
                     state <= ARB_IDLE;
                     gnt_q <= '0;
                  end
               end
`ifdef GRID_ARB_TIMEOUT_EN
               else if (!hold_expired) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
`endif
            end
            default: begin
               state <= ARB_IDLE;
               gnt_q <= '0;
            end
         endcase
      end
   end

   // Memory mux driven straight from the grant register, so reset clears it without a clock.
   logic [GRID_ADDR_W-1:0] mux_addr;
   logic                   mux_we;
   logic [GRID_DATA_W-1:0] mux_wdata;

   always_comb begin
      mux_addr  = '0;
      mux_we    = 1'b0;
      mux_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) begin
            mux_addr  = bus.req_addr[i*GRID_ADDR_W +: GRID_ADDR_W];
            mux_we    = bus.req_we[i];
            mux_wdata = bus.req_wdata[i*GRID_DATA_W +: GRID_DATA_W];
         end
      end
   end

   assign bus.mem_addr  = mux_addr;
   assign bus.mem_we    = mux_we;
   assign bus.mem_wdata = mux_wdata;
   assign bus.gnt       = gnt_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Bench for grid_mem_arbiter: vector table, corner-case sequences, randomized model comparison.
module tb_grid_mem_arbiter;
   import grid_pkg::*;

   localparam int TB_MAX_HOLD = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   grid_mem_arbiter_if #(.NUM_REQ(3)) bus();

   grid_mem_arbiter #(.NUM_REQ(3), .MAX_HOLD(TB_MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Grid memory macro: synchronous read-first, one cycle latency.
   logic [7:0] gmem [256];

   function automatic logic [7:0] preload(int i);
      logic [7:0] a;
      a = 8'(i);
      return (i == 13) ? 8'h05 : (a ^ 8'hA5);
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) gmem[i] = preload(i);
      forever begin
         @(posedge clk);
         bus.mem_rdata <= gmem[bus.mem_addr];
         if (bus.mem_we) gmem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [2:0] r, input logic [2:0] w,
                        input logic [23:0] a, input logic [23:0] d);
      bus.req       = r;
      bus.req_we    = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(3'b000, 3'b000, 24'h0, 24'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic [2:0]  req;
      logic [2:0]  we;
      logic [23:0] addr;
      logic [23:0] wdata;
      logic [2:0]  gnt;
      logic [2:0]  rvalid;
      logic        mem_we;
      logic [7:0]  mem_addr;
      logic [7:0]  mem_wdata;
      logic        chk_rd;
      logic [7:0]  rdata;
   } vec_t;

   vec_t tbl [17];

   // Reference arbitration: next requester after 'start' in rotating order, -1 if none.
   function automatic int first_from(int start, logic [2:0] mask);
      for (int k = 1; k <= 3; k++) begin
         int j;
         j = (start + k) % 3;
         if (mask[2'(j)]) return j;
      end
      return -1;
   endfunction

   initial begin
      logic [2:0] held [3];
      logic [2:0] obs;
      int         run;
      bit         in_run;
      logic [2:0] after_run;
      int         m_owner, m_last, m_owned;
      logic [2:0] m_rvalid;
      logic [7:0] m_rdata;
      bit         rd_known;
      logic [7:0] ref_mem [256];
      int         rem [3];
      logic [2:0] r_req, c_we;
      logic [23:0] c_addr, c_wdata;
      logic [2:0] e_gnt;
      logic       e_we;
      logic [7:0] e_addr, e_wdata;

      //                req     we      addr {2,1,0}  wdata        gnt     rvalid  mwe   maddr  mwdata chk rdata
      tbl[0]  = '{3'b001, 3'b000, 24'h00000D, 24'h000000, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
      tbl[1]  = '{3'b001, 3'b000, 24'h00000D, 24'h000000, 3'b001, 3'b000, 1'b0, 8'h0D, 8'h00, 1'b0, 8'h00};
      tbl[2]  = '{3'b000, 3'b000, 24'h00000D, 24'h000000, 3'b001, 3'b001, 1'b0, 8'h0D, 8'h00, 1'b1, 8'h05};
      tbl[3]  = '{3'b000, 3'b000, 24'h00000D, 24'h000000, 3'b000, 3'b001, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05};
      tbl[4]  = '{3'b001, 3'b010, 24'h002814, 24'h00FF00, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
      tbl[5]  = '{3'b001, 3'b010, 24'h002814, 24'h00FF00, 3'b001, 3'b000, 1'b0, 8'h14, 8'h00, 1'b0, 8'h00};
      tbl[6]  = '{3'b000, 3'b000, 24'h002814, 24'h00FF00, 3'b001, 3'b001, 1'b0, 8'h14, 8'h00, 1'b1, 8'hB1};
      tbl[7]  = '{3'b010, 3'b000, 24'h002814, 24'h00FF00, 3'b000, 3'b001, 1'b0, 8'h00, 8'h00, 1'b1, 8'hB1};
      tbl[8]  = '{3'b010, 3'b000, 24'h002814, 24'h00FF00, 3'b010, 3'b000, 1'b0, 8'h28, 8'hFF, 1'b0, 8'h00};
      tbl[9]  = '{3'b000, 3'b000, 24'h002814, 24'h00FF00, 3'b010, 3'b010, 1'b0, 8'h28, 8'hFF, 1'b1, 8'h8D};
      tbl[10] = '{3'b000, 3'b000, 24'h002814, 24'h00FF00, 3'b000, 3'b010, 1'b0, 8'h00, 8'h00, 1'b1, 8'h8D};
      tbl[11] = '{3'b100, 3'b100, 24'h322814, 24'h3CFF00, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
      tbl[12] = '{3'b100, 3'b100, 24'h322814, 24'h3CFF00, 3'b100, 3'b000, 1'b1, 8'h32, 8'h3C, 1'b0, 8'h00};
      tbl[13] = '{3'b100, 3'b000, 24'h322814, 24'h3CFF00, 3'b100, 3'b000, 1'b0, 8'h32, 8'h3C, 1'b1, 8'h97};
      tbl[14] = '{3'b000, 3'b000, 24'h322814, 24'h3CFF00, 3'b100, 3'b100, 1'b0, 8'h32, 8'h3C, 1'b1, 8'h3C};
      tbl[15] = '{3'b000, 3'b000, 24'h322814, 24'h3CFF00, 3'b000, 3'b100, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3C};
      tbl[16] = '{3'b000, 3'b000, 24'h322814, 24'h3CFF00, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA5};

      // ---------------- reset state ----------------
      rst = 1'b1;
      drive(3'b000, 3'b000, 24'h0, 24'h0);
      #2 rst = 1'b0;
      #1;
      check("reset_gnt",    32'(bus.gnt),      32'h0);
      check("reset_rvalid", 32'(bus.rvalid),   32'h0);
      check("reset_mem_we", 32'(bus.mem_we),   32'h0);
      check("reset_addr",   32'(bus.mem_addr), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // ---------------- vector table ----------------
      for (int v = 0; v < 17; v++) begin
         @(negedge clk);
         drive(tbl[v].req, tbl[v].we, tbl[v].addr, tbl[v].wdata);
         #1;
         check($sformatf("vec%0d_gnt", v),       32'(bus.gnt),       32'(tbl[v].gnt));
         check($sformatf("vec%0d_rvalid", v),    32'(bus.rvalid),    32'(tbl[v].rvalid));
         check($sformatf("vec%0d_mem_we", v),    32'(bus.mem_we),    32'(tbl[v].mem_we));
         check($sformatf("vec%0d_mem_addr", v),  32'(bus.mem_addr),  32'(tbl[v].mem_addr));
         check($sformatf("vec%0d_mem_wdata", v), 32'(bus.mem_wdata), 32'(tbl[v].mem_wdata));
         if (tbl[v].chk_rd)
            check($sformatf("vec%0d_rdata", v),  32'(bus.rdata),     32'(tbl[v].rdata));
      end

      // ---------------- contention: each owner holds 4 granted cycles ----------------
      do_reset();
      for (int i = 0; i < 3; i++) held[i] = 3'd0;
      @(negedge clk);
      drive(3'b111, 3'b000, 24'h030201, 24'h0);
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         obs = bus.gnt;
         check($sformatf("contend_c%0d", c), 32'(obs), (c < 12) ? (32'h1 << (c / 4)) : 32'h0);
         for (int i = 0; i < 3; i++) begin
            if (obs[i]) begin
               held[i] = held[i] + 3'd1;
               if (held[i] == 3'd4) bus.req[i] = 1'b0;
            end
         end
      end

      // ---------------- long hold by requester 1 while requester 0 waits ----------------
      do_reset();
      @(negedge clk);
      drive(3'b010, 3'b000, 24'h0, 24'h0);
      @(negedge clk);
      bus.req = 3'b011;
      run = 0;
      in_run = 1'b1;
      after_run = 3'b000;
      for (int s = 0; s < 200; s++) begin
         if (in_run) begin
            if (bus.gnt == 3'b010) run++;
            else begin
               in_run = 1'b0;
               after_run = bus.gnt;
            end
         end
         @(negedge clk);
      end
`ifdef GRID_ARB_TIMEOUT_EN
      check("timeout_hold_len", 32'(run), 32'(TB_MAX_HOLD));
      check("timeout_next_gnt", 32'(after_run), 32'h1);
`else
      check("no_timeout_hold_len", 32'(run), 32'd200);
`endif

      // ---------------- async reset in the middle of a write burst ----------------
      do_reset();
      @(negedge clk);
      drive(3'b100, 3'b000, 24'h4D0000, 24'h990000);
      @(negedge clk);
      @(negedge clk);
      bus.req_we = 3'b100;
      #1;
      check("midrst_pre_gnt",    32'(bus.gnt),    32'h4);
      check("midrst_pre_we",     32'(bus.mem_we), 32'h1);
      check("midrst_pre_rvalid", 32'(bus.rvalid), 32'h4);
      #1 rst = 1'b0;
      #1;
      check("midrst_gnt",    32'(bus.gnt),      32'h0);
      check("midrst_we",     32'(bus.mem_we),   32'h0);
      check("midrst_rvalid", 32'(bus.rvalid),   32'h0);
      check("midrst_addr",   32'(bus.mem_addr), 32'h0);
      @(negedge clk);
      check("midrst_hold_gnt", 32'(bus.gnt), 32'h0);
      rst = 1'b1;
      bus.req_we = 3'b000;
      @(negedge clk);
      check("midrst_regrant", 32'(bus.gnt), 32'h4);

      // ---------------- randomized run against the reference model ----------------
      do_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
      ref_mem[50] = 8'h3C;
      m_owner = -1; m_last = 2; m_owned = 0;
      m_rvalid = 3'b000; m_rdata = 8'h00; rd_known = 1'b0;
      r_req = 3'b000;
      for (int i = 0; i < 3; i++) rem[i] = 0;

      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (r_req[i]) begin
               if (m_owner == i) begin
                  rem[i]--;
                  if (rem[i] == 0) r_req[i] = 1'b0;
               end
            end else if ($urandom_range(3) == 0) begin
               r_req[i] = 1'b1;
               rem[i] = ($urandom_range(15) == 0) ? int'($urandom_range(70, 100))
                                                  : int'($urandom_range(1, 6));
            end
         end
         c_we = 3'($urandom);
         for (int i = 0; i < 3; i++) begin
            c_addr[i*8 +: 8]  = 8'($urandom_range(0, 15));
            c_wdata[i*8 +: 8] = 8'($urandom);
         end
         drive(r_req, c_we, c_addr, c_wdata);

         e_gnt = 3'b000; e_we = 1'b0; e_addr = 8'h00; e_wdata = 8'h00;
         if (m_owner >= 0) begin
            e_gnt   = 3'b001 << m_owner;
            e_we    = c_we[m_owner];
            e_addr  = c_addr[m_owner*8 +: 8];
            e_wdata = c_wdata[m_owner*8 +: 8];
         end
         #1;
         check("rand_gnt",       32'(bus.gnt),       32'(e_gnt));
         check("rand_rvalid",    32'(bus.rvalid),    32'(m_rvalid));
         check("rand_mem_we",    32'(bus.mem_we),    32'(e_we));
         check("rand_mem_addr",  32'(bus.mem_addr),  32'(e_addr));
         check("rand_mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
         if (rd_known) check("rand_rdata", 32'(bus.rdata), 32'(m_rdata));

         @(posedge clk);
         // Memory: read-first, then commit the granted write.
         m_rdata  = ref_mem[e_addr];
         rd_known = 1'b1;
         if (e_we) ref_mem[e_addr] = e_wdata;
         m_rvalid = (m_owner >= 0 && !c_we[m_owner]) ? (3'b001 << m_owner) : 3'b000;

         if (m_owner < 0) begin
            m_owner = first_from(m_last, r_req);
            m_owned = 1;
         end else if (!r_req[m_owner]) begin
            m_last  = m_owner;
            m_owner = first_from(m_owner, r_req);
            m_owned = 1;
         end else begin
`ifdef GRID_ARB_TIMEOUT_EN
            if (m_owned >= TB_MAX_HOLD && (r_req & ~(3'b001 << m_owner)) != 3'b000) begin
               m_last  = m_owner;
               m_owner = first_from(m_owner, r_req & ~(3'b001 << m_owner));
               m_owned = 1;
            end else begin
               m_owned++;
            end
`else
            m_owned++;
`endif
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
